// File: rtl/bit_serial_accumulator.sv
// bit_serial_accumulator: weights each incoming bit-plane partial sum by 2^bit and
// accumulates IN_BITS planes into one MAC result. The result is handed off on a
// valid/ready handshake.
// Optional feature macro: SIGNED_INPUT_EN. When it is defined, the activations are
// two's complement and the MSB plane is subtracted.
module bit_serial_accumulator #(
    parameter int PSUM_W  = 12,
    parameter int IN_BITS = 8,
    parameter int ACC_W   = PSUM_W + IN_BITS,
    parameter int IDX_W   = $clog2(IN_BITS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              clr_i,
    input  logic              in_valid_i,
    input  logic [PSUM_W-1:0] psum_i,
    output logic              busy_o,
    output logic [IDX_W-1:0]  bit_idx_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  result_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(IN_BITS - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   acc_sum;

    // Zero-extend the plane sum and weight it by its bit position; add or subtract it.
    always_comb begin
        term    = {{(ACC_W-PSUM_W){1'b0}}, psum_i} << idx_q;
`ifdef SIGNED_INPUT_EN
        acc_sum = (idx_q == LAST) ? (acc_q - term) : (acc_q + term);
`else
        acc_sum = acc_q + term;
`endif
    end

    // Next-state logic. clr overrides everything, and result is never cleared by it.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        if (clr_i) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        idx_d   = '0;
                    end
                end
                ACCUM: begin
                    if (in_valid_i) begin
                        acc_d = acc_sum;
                        if (idx_q == LAST) begin
                            state_d  = DONE;
                            result_d = acc_sum;
                            idx_d    = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A start on the handshake cycle chains straight into the next MAC.
                    if (out_ready_i) begin
                        state_d = start_i ? ACCUM : IDLE;
                        acc_d   = '0;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    assign busy_o      = (state_q == ACCUM);
    assign out_valid_o = (state_q == DONE);
    assign bit_idx_o   = idx_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_bit_serial_accumulator.sv
// Directed bench for bit_serial_accumulator. Inputs change 1ns after the rising edge,
// and the outputs are checked at that same point.
module tb_bit_serial_accumulator;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i, clr_i, in_valid_i, out_ready_i;
    logic [11:0] psum_i;
    logic        busy_o, out_valid_o;
    logic [2:0]  bit_idx_o;
    logic [19:0] result_o;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SIGNED_INPUT_EN
    localparam logic [19:0] EXP_FULL = 20'hFF010;   // 4080*127 - 4080*128 = -4080
    localparam logic [19:0] EXP_ONES = 20'hFFFFF;   // 127 - 128 = -1
    localparam logic [19:0] EXP_TWOS = 20'hFFFFE;   // 254 - 256 = -2
`else
    localparam logic [19:0] EXP_FULL = 20'hFE010;   // 1040400
    localparam logic [19:0] EXP_ONES = 20'd255;
    localparam logic [19:0] EXP_TWOS = 20'd510;
`endif

    bit_serial_accumulator dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .clr_i(clr_i),
        .in_valid_i(in_valid_i), .psum_i(psum_i), .busy_o(busy_o),
        .bit_idx_o(bit_idx_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic plane(input logic [11:0] p);
        in_valid_i = 1'b1;
        psum_i     = p;
        step();
        in_valid_i = 1'b0;
        psum_i     = '0;
    endtask

    logic [19:0] held;

    initial begin
        rst_n_i = 1'b0; start_i = 0; clr_i = 0; in_valid_i = 0; out_ready_i = 0; psum_i = '0;
        #12;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_idx", bit_idx_o, 0);
        chk("rst_result", result_o, 0);
        rst_n_i = 1'b1;
        step();

        // 1: async reset mid-ACCUM, then a clean MAC
        do_start();
        chk("t1_busy", busy_o, 1);
        for (int i = 0; i < 3; i++) plane(12'd100);
        chk("t1_idx3", bit_idx_o, 3);
        rst_n_i = 1'b0;
        #2;
        chk("t1_rst_busy", busy_o, 0);
        chk("t1_rst_idx", bit_idx_o, 0);
        chk("t1_rst_valid", out_valid_o, 0);
        chk("t1_rst_result", result_o, 0);
        rst_n_i = 1'b1;
        step();
        do_start();
        for (int i = 0; i < 8; i++) plane(12'd1);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_result", result_o, EXP_ONES);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("t1_hs_valid", out_valid_o, 0);
        chk("t1_hs_busy", busy_o, 0);

        // 2: full scale, no gaps, latency of 8 cycles
        do_start();
        for (int i = 0; i < 7; i++) plane(12'd4080);
        chk("t2_not_yet", out_valid_o, 0);
        chk("t2_busy7", busy_o, 1);
        plane(12'd4080);
        chk("t2_valid", out_valid_o, 1);
        chk("t2_result", result_o, EXP_FULL);
        chk("t2_busy_done", busy_o, 0);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("t2_hs_valid", out_valid_o, 0);
        chk("t2_keep", result_o, EXP_FULL);

        // 3: gaps and backpressure; planes at bits 0 and 3 give 9 in both modes
        do_start();
        plane(12'd1);
        step(); step();
        chk("t3_gap_idx", bit_idx_o, 1);
        chk("t3_gap_busy", busy_o, 1);
        plane(12'd0);
        plane(12'd0);
        plane(12'd1);
        for (int i = 4; i < 8; i++) plane(12'd0);
        chk("t3_valid", out_valid_o, 1);
        chk("t3_result", result_o, 9);
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1; psum_i = 12'd4080;    // stray plane while waiting in DONE
            step();
            chk("t3_hold_valid", out_valid_o, 1);
            chk("t3_hold_result", result_o, 9);
        end
        in_valid_i = 1'b0; psum_i = '0;

        // 4: handshake and start together chain directly into the next MAC
        out_ready_i = 1'b1; start_i = 1'b1;
        step();
        out_ready_i = 1'b0; start_i = 1'b0;
        chk("t4_b2b_busy", busy_o, 1);
        chk("t4_b2b_valid", out_valid_o, 0);
        chk("t4_b2b_idx", bit_idx_o, 0);
        chk("t4_keep9", result_o, 9);
        for (int i = 0; i < 8; i++) begin
            start_i = (i == 3);                       // start in ACCUM is ignored
            plane(12'd2);
            start_i = 1'b0;
            if (i == 3) chk("t4_idx_after_start", bit_idx_o, 4);
        end
        chk("t4_valid", out_valid_o, 1);
        chk("t4_result", result_o, EXP_TWOS);
        start_i = 1'b1;                               // start in DONE without out_ready is ignored
        step();
        start_i = 1'b0;
        chk("t4_start_no_ready", out_valid_o, 1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;

        // 5: clr mid-MAC with start in the same cycle, then stray in_valid in IDLE
        do_start();
        for (int i = 0; i < 5; i++) plane(12'd7);
        chk("t5_idx5", bit_idx_o, 5);
        clr_i = 1'b1; start_i = 1'b1;
        step();
        clr_i = 1'b0; start_i = 1'b0;
        chk("t5_clr_busy", busy_o, 0);
        chk("t5_clr_idx", bit_idx_o, 0);
        chk("t5_clr_result", result_o, EXP_TWOS);
        for (int i = 0; i < 12; i++) begin
            in_valid_i = 1'b1; psum_i = 12'd4080;
            step();
            chk("t5_idle_valid", out_valid_o, 0);
            chk("t5_idle_busy", busy_o, 0);
        end
        in_valid_i = 1'b0; psum_i = '0;
        chk("t5_idle_result", result_o, EXP_TWOS);
        do_start();
        plane(12'd0);
        plane(12'd3);
        for (int i = 2; i < 8; i++) plane(12'd0);
        chk("t5_clean_result", result_o, 6);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;

`ifdef SIGNED_INPUT_EN
        // 6: signed extremes
        do_start();
        for (int i = 0; i < 7; i++) plane(12'd0);
        plane(12'd4080);
        chk("t6_neg", result_o, 20'h80800);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        do_start();
        for (int i = 0; i < 7; i++) plane(12'd4080);
        plane(12'd0);
        chk("t6_pos", result_o, 20'd518160);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
`endif

        held = result_o;
        step();
        chk("final_keep", result_o, held);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
